fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pulls words from a registered-flag FIFO and presents them as a valid/ready stream.
// Latency: 3 cycles from the IDLE decision to the word sitting at the head of the output buffer.
// Backpressure: m_ready low fills the 2-entry buffer, and then no further FIFO read is issued.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    always_comb begin
        do_pop  = pop_rdy && (cnt_q != '0);
        do_push = push_vld && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stale entries stay in the array after a pop, so the head is gated to zero when empty.
    assign pop_vld = (cnt_q != '0);
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign count   = cnt_q;

endmodule

module fifo_stream_reader #(
    parameter int          DATA_WIDTH   = 8,
    parameter logic [15:0] WORD_CNT_RST = 16'h0000
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           word_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        rd_en_q, rd_en_d;
    logic        busy_q, busy_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  occ;
    logic        cap_vld;
    logic        pop_hs;

    // Only one read is ever in flight, and a new one starts only once the previous
    // word has been captured, so the buffer cannot overflow.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !buf_empty && (occ < 2'd2)) begin
                    state_d = REQ;
                end
            end
            REQ:     state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d    = (state_d == REQ);
        busy_d     = (state_d != IDLE);
        word_cnt_d = pop_hs ? word_cnt_q + 16'd1 : word_cnt_q;
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            word_cnt_q <= WORD_CNT_RST;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // buf_out is valid during CAPT, so the capture happens on the edge leaving CAPT.
    assign cap_vld = (state_q == CAPT);
    assign pop_hs  = m_valid && m_ready;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (2)
    ) u_out_buf (
        .clk      (rd_clk),
        .rst_n    (rst_n),
        .push_vld (cap_vld),
        .push_dat (buf_out),
        .pop_rdy  (m_ready),
        .pop_vld  (m_valid),
        .pop_dat  (m_data),
        .count    (occ)
    );

    assign rd_en    = rd_en_q;
    assign busy     = busy_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboarded bench for fifo_stream_reader with a behavioural registered-flag source FIFO.
// A second instance preloaded near the count wrap shares every input with the main one.
module tb_fifo_stream_reader;

    logic        rd_clk    = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic        buf_empty = 1'b1;
    logic [7:0]  buf_out   = 8'h00;
    logic        m_ready   = 1'b0;
    logic        rd_en, m_valid, busy;
    logic [7:0]  m_data;
    logic [15:0] word_cnt;
    logic        w_rd_en, w_m_valid, w_busy;
    logic [7:0]  w_m_data;
    logic [15:0] w_word_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  src[$];
    logic [7:0]  exp_q[$];
    int          rd_cnt = 0;
    bit          strict_gap = 1'b0;
    bit          pending = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_dat = 8'h00;
    longint      last_rd_t = -1;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .buf_empty(buf_empty),
        .buf_out(buf_out), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .word_cnt(word_cnt), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .WORD_CNT_RST(16'hFFFE)) u_wrap (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .buf_empty(buf_empty),
        .buf_out(buf_out), .rd_en(w_rd_en), .m_data(w_m_data), .m_valid(w_m_valid),
        .m_ready(m_ready), .word_cnt(w_word_cnt), .busy(w_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] w, input bit expect_out);
        src.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && !m_valid && !busy)) begin
            tick(1);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_rd(input string name, input int budget);
        int k = 0;
        while (k < budget && !rd_en) begin
            tick(1);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    // Source FIFO: data appears in the cycle after the edge that sampled rd_en, flag registered.
    initial begin
        forever begin
            @(negedge rd_clk);
            if (pending) buf_out = (src.size() != 0) ? src.pop_front() : 8'hEE;
            if (rst_n && rd_en) check("rd_src_avail", 32'(src.size() > 0), 32'd1);
            buf_empty = (src.size() == 0);
            pending   = rst_n && rd_en;
        end
    end

    // Output monitor: pops the scoreboard on every handshake and polices the read cadence.
    initial begin
        forever begin
            @(negedge rd_clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                last_rd_t  = -1;
            end else begin
                if (rd_en) begin
                    rd_cnt++;
                    if (last_rd_t >= 0) begin
                        if (strict_gap)
                            check("rd_gap", 32'(($time - last_rd_t) / 10), 32'd3);
                        else if (($time - last_rd_t) / 10 < 3)
                            check("rd_gap_min", 32'(($time - last_rd_t) / 10), 32'd3);
                    end
                    last_rd_t = $time;
                end
                if (prev_stall) begin
                    check("hold_vld", 32'(m_valid), 32'd1);
                    check("hold_dat", 32'(m_data), 32'(prev_dat));
                end
                if (!m_valid) check("m_data_empty", 32'(m_data), 32'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
                    end else begin
                        check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_dat   = m_data;
            end
        end
    end

    initial begin
        // Reset values
        tick(2);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wrap_cnt", 32'(w_word_cnt), 32'hFFFE);
        rst_n = 1'b1;
        tick(1);

        // Streaming at full rate: reads every third cycle, three words in order
        strict_gap = 1'b1;
        m_ready    = 1'b1;
        push_word(8'h11, 1'b1);
        push_word(8'h22, 1'b1);
        push_word(8'h33, 1'b1);
        enable = 1'b1;
        wait_idle("s1_done", 60);
        strict_gap = 1'b0;
        check("s1_reads", 32'(rd_cnt), 32'd3);
        check("s1_word_cnt", 32'(word_cnt), 32'd3);
        check("wrap_word_cnt", 32'(w_word_cnt), 32'h0001);
        check("wrap_idle", {w_rd_en, w_m_valid, w_busy, w_m_data}, 32'd0);

        // Consumer stalled: buffer fills to two, reads stop, then drain resumes reads
        m_ready = 1'b0;
        rd_cnt  = 0;
        push_word(8'hA1, 1'b1);
        push_word(8'hA2, 1'b1);
        push_word(8'hA3, 1'b1);
        push_word(8'hA4, 1'b1);
        tick(20);
        check("s2_reads_stalled", 32'(rd_cnt), 32'd2);
        check("s2_src_left", 32'(src.size()), 32'd2);
        check("s2_m_valid", 32'(m_valid), 32'd1);
        check("s2_head", 32'(m_data), 32'hA1);
        check("s2_rd_en", 32'(rd_en), 32'd0);
        check("s2_busy", 32'(busy), 32'd0);
        m_ready = 1'b1;
        wait_idle("s2_drain", 60);
        check("s2_reads_total", 32'(rd_cnt), 32'd4);
        check("s2_word_cnt", 32'(word_cnt), 32'd7);

        // Source empty after the last read: the block stays idle
        tick(6);
        check("s3_no_read", 32'(rd_cnt), 32'd4);
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_m_valid", 32'(m_valid), 32'd0);

        // Enable dropped during REQ: the in-flight word still arrives, nothing further is read
        rd_cnt = 0;
        push_word(8'h5A, 1'b1);
        push_word(8'h5B, 1'b0);
        wait_rd("s4_rd", 20);
        enable = 1'b0;
        wait_idle("s4_done", 40);
        tick(6);
        check("s4_reads", 32'(rd_cnt), 32'd1);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_rd_en", 32'(rd_en), 32'd0);
        check("s4_src_left", 32'(src.size()), 32'd1);
        check("s4_word_cnt", 32'(word_cnt), 32'd8);

        // Reset in CAPT: the in-flight word is discarded
        src.delete();
        tick(1);
        enable = 1'b1;
        push_word(8'h77, 1'b0);
        wait_rd("s5_rd", 20);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("s5_rd_en", 32'(rd_en), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_m_valid", 32'(m_valid), 32'd0);
        check("s5_m_data", 32'(m_data), 32'd0);
        check("s5_word_cnt", 32'(word_cnt), 32'd0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        push_word(8'h88, 1'b1);
        wait_idle("s5_after", 40);
        check("s5_word_cnt_after", 32'(word_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
